// File: rtl/rx_pkg.sv
// Constants and state encoding shared by the cyclic-prefix inserter (TX) and remover (RX)
// so that both ends of the link agree on the symbol framing.
package rx_pkg;

    localparam int LCP_DEF  = 16;
    localparam int NFFT_DEF = 48;
    localparam int DW_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CP   = 2'd1,
        BODY = 2'd2
    } rx_state_e;

endpackage

// File: rtl/remove_cp.sv
// Receive-side cyclic-prefix remover: drops the first LCP samples of every symbol
// and forwards the NFFT body samples with start/end-of-symbol flags.
module remove_cp
    import rx_pkg::*;
#(
    parameter int LCP  = LCP_DEF,
    parameter int NFFT = NFFT_DEF,
    parameter int NSYM = 0,
    parameter int DW   = DW_DEF
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [DW-1:0] DAT_I_r,
    input  logic [DW-1:0] DAT_I_i,
    input  logic          STB_I,
    input  logic          SYNC_I,
    output logic [DW-1:0] DAT_O_r,
    output logic [DW-1:0] DAT_O_i,
    output logic          ACK_O,
    output logic          SOS_O,
    output logic          EOS_O,
    output logic [15:0]   SYM_CNT_O,
    output logic          BUSY_O,
    output logic          ERR_O
);

    localparam int CW = $clog2((LCP > NFFT) ? LCP : NFFT);
    localparam logic [CW-1:0] CP_LAST   = CW'(LCP - 1);
    localparam logic [CW-1:0] BODY_LAST = CW'(NFFT - 1);

    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   symCnt_q, symCnt_d;
    logic          boundary_q, boundary_d;
    logic [DW-1:0] datR_q, datR_d, datI_q, datI_d;
    logic          ack_q, ack_d, sos_q, sos_d, eos_q, eos_d;
    logic          err_q, err_d, busy_q;
    logic          lastBody;
    logic [15:0]   symInc;

    assign lastBody = (state_q == BODY) && (cnt_q == BODY_LAST);
    assign symInc   = symCnt_q + 16'd1;

    // SYNC_I is honoured in IDLE, CP and BODY except on the last body sample: that sample
    // is real payload, so it is forwarded with EOS and the sync request is dropped.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        symCnt_d   = symCnt_q;
        boundary_d = boundary_q;
        datR_d     = datR_q;
        datI_d     = datI_q;
        ack_d      = 1'b0;
        sos_d      = 1'b0;
        eos_d      = 1'b0;
        err_d      = 1'b0;
        if (STB_I) begin
            if (SYNC_I && !lastBody) begin
                err_d      = (state_q != IDLE) && !boundary_q;
                symCnt_d   = 16'd0;
                boundary_d = 1'b0;
                if (LCP == 1) begin
                    state_d = BODY;
                    cnt_d   = '0;
                end else begin
                    state_d = CP;
                    cnt_d   = CW'(1);
                end
            end else begin
                case (state_q)
                    CP: begin
                        boundary_d = 1'b0;
                        if (cnt_q == CP_LAST) begin
                            cnt_d   = '0;
                            state_d = BODY;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    BODY: begin
                        ack_d  = 1'b1;
                        datR_d = DAT_I_r;
                        datI_d = DAT_I_i;
                        sos_d  = (cnt_q == '0);
                        eos_d  = lastBody;
                        if (lastBody) begin
                            cnt_d      = '0;
                            symCnt_d   = symInc;
                            boundary_d = 1'b1;
                            state_d    = ((NSYM != 0) && (symInc == 16'(NSYM))) ? IDLE : CP;
                        end else begin
                            cnt_d      = cnt_q + CW'(1);
                            boundary_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            symCnt_q   <= 16'd0;
            boundary_q <= 1'b0;
            datR_q     <= '0;
            datI_q     <= '0;
            ack_q      <= 1'b0;
            sos_q      <= 1'b0;
            eos_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            symCnt_q   <= symCnt_d;
            boundary_q <= boundary_d;
            datR_q     <= datR_d;
            datI_q     <= datI_d;
            ack_q      <= ack_d;
            sos_q      <= sos_d;
            eos_q      <= eos_d;
            err_q      <= err_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    assign DAT_O_r   = datR_q;
    assign DAT_O_i   = datI_q;
    assign ACK_O     = ack_q;
    assign SOS_O     = sos_q;
    assign EOS_O     = eos_q;
    assign SYM_CNT_O = symCnt_q;
    assign BUSY_O    = busy_q;
    assign ERR_O     = err_q;

endmodule

// File: tb/tb_remove_cp.sv
// Bench for remove_cp: an unlimited-frame instance and an NSYM=3 instance share one input
// stream; a per-instance symbol-position model queues the expected output of every cycle.
module tb_remove_cp;
    import rx_pkg::*;

    localparam int LCP    = LCP_DEF;
    localparam int NFFT   = NFFT_DEF;
    localparam int DW     = DW_DEF;
    localparam int SYMLEN = LCP + NFFT;

    logic          clock = 1'b0;
    logic          rst;
    logic [DW-1:0] datR, datI;
    logic          stb, sync;

    logic [DW-1:0] uR, uI, fR, fI;
    logic          uAck, uSos, uEos, uBusy, uErr;
    logic          fAck, fSos, fEos, fBusy, fErr;
    logic [15:0]   uSym, fSym;

    typedef struct {
        logic          ack, sos, eos, err, busy;
        logic [DW-1:0] r, i;
        logic [15:0]   sym;
    } exp_t;

    typedef struct {
        bit active;
        int pos;
        int sym;
        bit bnd;
    } mdl_t;

    exp_t qU[$], qF[$];
    mdl_t mU, mF;
    int   nVec = 0;
    int   nMis = 0;

    always #5 clock = ~clock;

    remove_cp #(.LCP(LCP), .NFFT(NFFT), .NSYM(0), .DW(DW)) dutU (
        .CLK_I(clock), .RST_I(rst), .DAT_I_r(datR), .DAT_I_i(datI), .STB_I(stb), .SYNC_I(sync),
        .DAT_O_r(uR), .DAT_O_i(uI), .ACK_O(uAck), .SOS_O(uSos), .EOS_O(uEos),
        .SYM_CNT_O(uSym), .BUSY_O(uBusy), .ERR_O(uErr)
    );

    remove_cp #(.LCP(LCP), .NFFT(NFFT), .NSYM(3), .DW(DW)) dutF (
        .CLK_I(clock), .RST_I(rst), .DAT_I_r(datR), .DAT_I_i(datI), .STB_I(stb), .SYNC_I(sync),
        .DAT_O_r(fR), .DAT_O_i(fI), .ACK_O(fAck), .SOS_O(fSos), .EOS_O(fEos),
        .SYM_CNT_O(fSym), .BUSY_O(fBusy), .ERR_O(fErr)
    );

    // Position-in-symbol model: pos is the index (CP included) of the next accepted sample.
    task automatic modelStep(inout mdl_t m, input int nsym, input bit s, input bit sy,
                             input logic [DW-1:0] r, input logic [DW-1:0] i, output exp_t e);
        e.ack = 1'b0; e.sos = 1'b0; e.eos = 1'b0; e.err = 1'b0; e.r = r; e.i = i;
        if (s) begin
            if (sy && !(m.active && m.pos == SYMLEN - 1)) begin
                e.err    = m.active && !m.bnd;
                m.active = 1'b1;
                m.pos    = 1;
                m.sym    = 0;
                m.bnd    = 1'b0;
            end else if (m.active) begin
                if (m.pos >= LCP) begin
                    e.ack = 1'b1;
                    e.sos = (m.pos == LCP);
                    e.eos = (m.pos == SYMLEN - 1);
                end
                m.pos++;
                m.bnd = 1'b0;
                if (m.pos == SYMLEN) begin
                    m.pos = 0;
                    m.sym++;
                    m.bnd = 1'b1;
                    if (nsym != 0 && m.sym == nsym) m.active = 1'b0;
                end
            end
        end
        e.sym  = 16'(m.sym);
        e.busy = m.active;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nVec++;
        assert (obs === expv) else begin
            nMis++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic checkOne(input string who, input exp_t e, input logic ack, input logic sos,
                            input logic eos, input logic err, input logic busy,
                            input logic [DW-1:0] r, input logic [DW-1:0] i, input logic [15:0] sym);
        chk({who, ".ack"}, 32'(ack), 32'(e.ack));
        chk({who, ".err"}, 32'(err), 32'(e.err));
        chk({who, ".busy"}, 32'(busy), 32'(e.busy));
        chk({who, ".symcnt"}, 32'(sym), 32'(e.sym));
        if (e.ack) begin
            chk({who, ".dat_r"}, 32'(r), 32'(e.r));
            chk({who, ".dat_i"}, 32'(i), 32'(e.i));
            chk({who, ".sos"}, 32'(sos), 32'(e.sos));
            chk({who, ".eos"}, 32'(eos), 32'(e.eos));
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (qU.size() == 0 || qF.size() == 0) begin
            chk("scoreboard.empty", 32'(qU.size() + qF.size()), 32'd2);
        end else begin
            e = qU.pop_front();
            checkOne("unl", e, uAck, uSos, uEos, uErr, uBusy, uR, uI, uSym);
            e = qF.pop_front();
            checkOne("nsym3", e, fAck, fSos, fEos, fErr, fBusy, fR, fI, fSym);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit sy, input logic [DW-1:0] r);
        exp_t e;
        logic [DW-1:0] im;
        im = ~r;
        @(negedge clock);
        stb = s; sync = sy; datR = r; datI = im;
        modelStep(mU, 0, s, sy, r, im, e);
        qU.push_back(e);
        modelStep(mF, 3, s, sy, r, im, e);
        qF.push_back(e);
        @(posedge clock);
        #1;
        checkOutput();
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, ".unl.outs"}, 32'({uAck, uSos, uEos, uErr, uBusy}), 32'd0);
        chk({tag, ".unl.data"}, {uR, uI}, 32'd0);
        chk({tag, ".unl.symcnt"}, 32'(uSym), 32'd0);
        chk({tag, ".nsym3.outs"}, 32'({fAck, fSos, fEos, fErr, fBusy}), 32'd0);
        chk({tag, ".nsym3.data"}, {fR, fI}, 32'd0);
        chk({tag, ".nsym3.symcnt"}, 32'(fSym), 32'd0);
    endtask

    task automatic resetModels();
        mU = '{1'b0, 0, 0, 1'b0};
        mF = '{1'b0, 0, 0, 1'b0};
        qU.delete();
        qF.delete();
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; sync = 1'b0; datR = '0; datI = '0;
        resetModels();
        repeat (2) @(posedge clock);
        #1;
        checkAllZero("reset");
        @(negedge clock);
        rst = 1'b0;

        // One symbol of 0..63 with sync on sample 0.
        for (int k = 0; k < 64; k++) applyStimulus(1'b1, k == 0, DW'(k));

        // Three contiguous symbols; the NSYM=3 instance must drop back to IDLE.
        for (int k = 0; k < 192; k++) applyStimulus(1'b1, k == 0, DW'(16'h100 + k));
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0, DW'(16'h400 + k));

        // 50% duty strobe across one symbol; sync lands mid-CP on the unlimited instance.
        for (int k = 0; k < 64; k++) begin
            applyStimulus(1'b0, 1'b0, DW'($urandom));
            applyStimulus(1'b1, k == 0, DW'(16'h500 + k));
        end

        // Resync at body sample 20, then a complete fresh symbol.
        for (int k = 0; k < 37; k++) applyStimulus(1'b1, k == 0 || k == 36, DW'(16'h600 + k));
        for (int k = 1; k < 64; k++) applyStimulus(1'b1, 1'b0, DW'(16'h700 + k));

        // Sync right after EOS (no error); sync on a last body sample is ignored.
        for (int k = 0; k < 64; k++) applyStimulus(1'b1, k == 0 || k == 63, DW'(16'h800 + k));
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, DW'(16'h900 + k));

        // Asynchronous reset while body sample 30 is on the inputs.
        for (int k = 0; k < 46; k++) applyStimulus(1'b1, k == 0, DW'(16'hA00 + k));
        @(negedge clock);
        stb = 1'b1; sync = 1'b0; datR = DW'(16'hA2E); datI = ~DW'(16'hA2E);
        #2 rst = 1'b1;
        #1;
        checkAllZero("async_reset");
        @(negedge clock);
        resetModels();
        rst = 1'b0; stb = 1'b0;
        for (int k = 0; k < 70; k++) applyStimulus(1'b1, 1'b0, DW'(16'hB00 + k));
        for (int k = 0; k < 64; k++) applyStimulus(1'b1, k == 0, DW'(16'hC00 + k));
        applyStimulus(1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/remove_cp.md
Name: remove_cp

Overview:
- Receive-side counterpart of the transmit cyclic-prefix inserter.
- Takes a contiguous stream of complex time-domain samples framed as symbols of LCP+NFFT samples.
- Discards the first LCP samples of each symbol and forwards the NFFT body samples to the receive FFT, with symbol-boundary flags.
- Sits between the RX sample front end (after frame sync) and the FFT input.

Parameters:
- LCP, 16, cyclic-prefix length in samples (>=1).
- NFFT, 48, body length in samples per symbol (>=2).
- NSYM, 0, symbols per frame; 0 = unlimited, only resync or reset ends the frame.
- DW, 16, width of each real/imag sample.

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  reset, asynchronous, active-high.
- DAT_I_r  in  DW  input sample, real part.
- DAT_I_i  in  DW  input sample, imag part.
- STB_I  in  1  input sample valid; one sample per cycle when high.
- SYNC_I  in  1  qualified by STB_I; marks the sample as CP sample 0 of the first symbol of a frame.
- DAT_O_r  out  DW  output body sample, real part.
- DAT_O_i  out  DW  output body sample, imag part.
- ACK_O  out  1  output valid.
- SOS_O  out  1  with ACK_O, first body sample of a symbol.
- EOS_O  out  1  with ACK_O, last body sample of a symbol.
- SYM_CNT_O  out  16  count of symbols completed in the current frame.
- BUSY_O  out  1  high when the FSM is not in IDLE.
- ERR_O  out  1  one-cycle pulse on resync mid-symbol.

Behaviour:
- Reset: all outputs 0, FSM IDLE, sample counter 0, symbol counter 0. Reset mid-symbol aborts the symbol immediately; no partial output follows.
- FSM states: IDLE, CP, BODY. A sample counter (width clog2(max(LCP,NFFT))) counts accepted samples within the current state.
- The FSM advances only on cycles with STB_I=1. Gaps hold all state and counters. ACK_O is 0 on gap cycles.
- IDLE:
  - STB_I & SYNC_I: sample is CP[0] and is discarded. Counter <= 1. Next state is CP, or BODY with counter 0 if LCP==1.
  - STB_I without SYNC_I: sample ignored.
- CP:
  - Each STB_I sample is discarded and the counter increments.
  - On accepting CP sample LCP-1: counter <= 0, next state BODY.
- BODY:
  - Each STB_I sample is registered to DAT_O_r/DAT_O_i with ACK_O=1 on the next cycle. Latency is exactly 1 cycle.
  - SOS_O=1 when the counter was 0. EOS_O=1 when the counter was NFFT-1.
  - On accepting body sample NFFT-1: SYM_CNT_O increments and the counter resets to 0.
  - Next state after the last body sample: IDLE if NSYM!=0 and the incremented count equals NSYM; otherwise CP, so back-to-back symbols need no SYNC_I.
- SYM_CNT_O: holds its value in IDLE. Cleared to 0 on each accepted SYNC_I. Wraps at 2^16.
- Resync (STB_I & SYNC_I while in CP or BODY):
  - The sample is treated as CP[0] of a new frame: counter <= 1, state CP (or BODY if LCP==1), SYM_CNT_O <= 0.
  - ERR_O pulses if the resync is not at a symbol boundary.
  - A boundary means the previous accepted sample was BODY sample NFFT-1. In that case there is no ERR_O.
  - A resync sample is never forwarded, even if it arrives in BODY.
- Last body sample and SYNC_I on the same STB_I cycle: the body sample is forwarded with EOS_O (it is a valid sample, not a sync). SYNC_I applies from the following accepted sample only if reasserted there. SYNC_I is therefore only honoured in IDLE, CP, or BODY with counter != NFFT-1. Document this priority in RTL comments.
- Output data holds its last value when ACK_O=0. Downstream must qualify with ACK_O.
- BUSY_O is registered from state != IDLE.
- No backpressure: the FFT consumer must accept one sample per cycle.

Decomposition:
- Shared package (rx_pkg):
  - LCP and NFFT default constants, shared with the TX inserter so both ends agree.
  - FSM state enum {IDLE, CP, BODY}.
  - Sample-width constant.
- No sub-module needed: a single FSM plus counters. The output register stage stays inline.

Test Plan:
- Defaults; SYNC_I on sample 0; 64 contiguous samples with values 0..63 -> ACK_O on 48 cycles carrying 16..63, first output one cycle after input 16, SOS_O with 16, EOS_O with 63, SYM_CNT_O=1.
- NSYM=3; 192 contiguous samples -> 3 bursts of 48, each starting at input offset 16/80/144. FSM returns to IDLE after the 192nd sample with SYM_CNT_O=3. Further samples without SYNC_I produce no ACK_O.
- STB_I toggling 1,0 (50% duty) across one symbol -> same 48 output values, ACK_O only on cycles following valid inputs, counters unaffected by gaps.
- SYNC_I reasserted at body sample 20 (input index 36) -> one ERR_O pulse. No output for that sample. The next 15 samples are discarded, then a fresh SOS_O. SYM_CNT_O=0.
- SYNC_I asserted on the first sample after an EOS_O in unlimited mode -> no ERR_O, SYM_CNT_O cleared to 0, next symbol output normally.
- RST_I pulsed asynchronously at body sample 30 -> all outputs 0 within the reset cycle, FSM IDLE. After release, no output until a new SYNC_I.
